bfsk_deframer: RTL

BFSK_DEFRAMER -- requirements
Module: bfsk_deframer

---
 rtl/bfsk_pkg.sv | 23 ++
 rtl/bfsk_deframer_if.sv | 29 ++
 rtl/bfsk_dpll.sv | 75 +++++++
 rtl/bfsk_deframer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bfsk_pkg.sv
// bfsk_pkg: shared constants and types for the BFSK HDLC deframer.
//   SPB_DEFAULT : samples per bit (1200 baud at 48 kHz)
//   ADJ_DEFAULT : DPLL phase nudge applied per detected edge
//   FLAG        : HDLC flag octet
//   state_t     : framing state (HUNT after reset, FRAME after a flag)
//   ones_inc    : saturating increment for the consecutive-ones counter
package bfsk_pkg;

  localparam int SPB_DEFAULT = 40;
  localparam int ADJ_DEFAULT = 1;
  localparam logic [7:0] FLAG = 8'h7E;

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } state_t;

  // The ones counter saturates at 7 so a long run of ones reports abort once.
  function automatic logic [2:0] ones_inc(input logic [2:0] ones);
    return (ones == 3'd7) ? 3'd7 : ones + 3'd1;
  endfunction

endpackage

// File: rtl/bfsk_deframer_if.sv
// bfsk_deframer_if: link between the discriminator side and the bit clock
// recovery block.
//   det     : hard tone decision (1 = upper tone)
//   en      : sample qualifier; logic only advances on en=1 cycles
//   bit_stb : one-cycle pulse per recovered bit
//   bit_out : NRZI-decoded bit, valid with bit_stb
// master = discriminator side (drives samples), slave = DPLL (returns bits).
interface bfsk_deframer_if;

  logic det;
  logic en;
  logic bit_stb;
  logic bit_out;

  modport master (
    output det,
    output en,
    input  bit_stb,
    input  bit_out
  );

  modport slave (
    input  det,
    input  en,
    output bit_stb,
    output bit_out
  );

endinterface

// File: rtl/bfsk_dpll.sv
// bfsk_dpll: digital PLL bit clock recovery plus NRZI decoding.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of bfsk_deframer_if (det/en in, bit_stb/bit_out out)
// A phase counter runs 0..SPB-1 on qualified samples. Each det transition
// nudges the phase so that edges settle at ph == SPB/2, which puts the
// sampling point (ph == SPB-1) near the middle of the bit.
module bfsk_dpll
  import bfsk_pkg::*;
#(
  parameter int SPB = SPB_DEFAULT,
  parameter int ADJ = ADJ_DEFAULT
) (
  input logic clk,
  input logic rst,
  bfsk_deframer_if.slave bus
);

  localparam int PW   = $clog2(SPB);
  localparam int HALF = SPB / 2;

  logic [PW-1:0] ph_reg, ph_next;
  logic          det_d_reg;
  logic          prev_reg;
  logic          bit_stb_reg;
  logic          bit_out_reg;
  logic          edge_det;
  logic          sample;
  int            step;

  always_comb begin
    edge_det = bus.det ^ det_d_reg;
    step     = 1;
    if (edge_det) begin
      // Edge early in the cycle means we sample late: speed up. Late edge: slow down.
      if (int'(ph_reg) < HALF) begin
        step = 1 + ADJ;
      end else if (int'(ph_reg) > HALF) begin
        step = 1 - ADJ;
      end
    end
    // A withheld step at the last phase postpones the sample by one sample.
    sample = (int'(ph_reg) == SPB - 1) && (step >= 1);
    if (sample) begin
      ph_next = '0;
    end else begin
      ph_next = PW'(int'(ph_reg) + step);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_reg      <= '0;
      det_d_reg   <= 1'b0;
      prev_reg    <= 1'b0;
      bit_stb_reg <= 1'b0;
      bit_out_reg <= 1'b0;
    end else begin
      bit_stb_reg <= 1'b0;
      if (bus.en) begin
        det_d_reg <= bus.det;
        ph_reg    <= ph_next;
        if (sample) begin
          bit_stb_reg <= 1'b1;
          // NRZI: no transition between sampled levels is a one.
          bit_out_reg <= (bus.det == prev_reg);
          prev_reg    <= bus.det;
        end
      end
    end
  end

  assign bus.bit_stb = bit_stb_reg;
  assign bus.bit_out = bit_out_reg;

endmodule

// File: rtl/bfsk_deframer.sv
// bfsk_deframer: HDLC deframer behind a BFSK discriminator.
//   clk, rst   : clock and synchronous active-high reset
//   det, en    : hard tone decision and its sample qualifier
//   bit_stb    : pulse per recovered bit; bit_out is the NRZI-decoded bit
//   dout       : received byte (LSB first on air), valid with dout_vld
//   dout_eof   : with dout_vld, marks the last byte of a frame
//   flag       : pulse per flag that does not close a frame with data
//   abort      : pulse on seven consecutive ones inside a frame
//   frame_err  : pulse on a closing flag after a non-byte-aligned frame
// Each completed byte is held in a one-deep pending slot, because only the
// next event (another byte or the closing flag) tells whether it is the last
// byte of the frame or garbage left over before a misaligned flag.
module bfsk_deframer
  import bfsk_pkg::*;
#(
  parameter int SPB = SPB_DEFAULT,
  parameter int ADJ = ADJ_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       det,
  input  logic       en,
  output logic       bit_stb,
  output logic       bit_out,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       dout_eof,
  output logic       flag,
  output logic       abort,
  output logic       frame_err
);

  bfsk_deframer_if dpll_bus ();

  assign dpll_bus.det = det;
  assign dpll_bus.en  = en;
  assign bit_stb      = dpll_bus.bit_stb;
  assign bit_out      = dpll_bus.bit_out;

  bfsk_dpll #(
    .SPB (SPB),
    .ADJ (ADJ)
  ) u_dpll (
    .clk (clk),
    .rst (rst),
    .bus (dpll_bus)
  );

  state_t     state_reg, state_next;
  logic [2:0] ones_reg, ones_next;
  logic [2:0] count_reg, count_next;
  logic [7:0] shreg_reg, shreg_next;
  logic [7:0] pend_reg, pend_next;
  logic       pend_vld_reg, pend_vld_next;
  logic [7:0] dout_reg, dout_next;
  logic       dout_vld_reg, dout_vld_next;
  logic       dout_eof_reg, dout_eof_next;
  logic       flag_reg, flag_next;
  logic       abort_reg, abort_next;
  logic       frame_err_reg, frame_err_next;
  logic       is_data, is_flag, is_abort;

  always_comb begin
    state_next     = state_reg;
    ones_next      = ones_reg;
    count_next     = count_reg;
    shreg_next     = shreg_reg;
    pend_next      = pend_reg;
    pend_vld_next  = pend_vld_reg;
    dout_next      = dout_reg;
    dout_vld_next  = 1'b0;
    dout_eof_next  = 1'b0;
    flag_next      = 1'b0;
    abort_next     = 1'b0;
    frame_err_next = 1'b0;
    is_data        = 1'b0;
    is_flag        = 1'b0;
    is_abort       = 1'b0;

    // Classify the bit against the run of ones that precedes it.
    if (bit_stb) begin
      if (bit_out) begin
        ones_next = ones_inc(ones_reg);
        is_data   = (ones_reg <= 3'd4);
        is_abort  = (ones_reg == 3'd6);
      end else begin
        ones_next = '0;
        is_data   = (ones_reg <= 3'd4);
        is_flag   = (ones_reg == 3'd6);
        // ones==5: stuffed zero, dropped. ones==7: tail of an abort, ignored.
      end
    end

    if (is_abort) begin
      abort_next    = (state_reg == FRAME);
      state_next    = HUNT;
      count_next    = '0;
      pend_vld_next = 1'b0;
    end else if (is_flag) begin
      if (state_reg == FRAME && pend_vld_reg) begin
        // A byte-aligned frame leaves the flag's leading 0 + five ones (6 bits)
        // in the shift register behind the last complete byte.
        if (count_reg == 3'd6) begin
          dout_next     = pend_reg;
          dout_vld_next = 1'b1;
          dout_eof_next = 1'b1;
        end else begin
          frame_err_next = 1'b1;
        end
      end else begin
        flag_next = 1'b1;
      end
      state_next    = FRAME;
      count_next    = '0;
      pend_vld_next = 1'b0;
    end else if (is_data && state_reg == FRAME) begin
      shreg_next = {bit_out, shreg_reg[7:1]};
      count_next = count_reg + 3'd1;
      if (count_reg == 3'd7) begin
        if (pend_vld_reg) begin
          dout_next     = pend_reg;
          dout_vld_next = 1'b1;
        end
        pend_next     = shreg_next;
        pend_vld_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      ones_reg      <= '0;
      count_reg     <= '0;
      shreg_reg     <= '0;
      pend_reg      <= '0;
      pend_vld_reg  <= 1'b0;
      dout_reg      <= '0;
      dout_vld_reg  <= 1'b0;
      dout_eof_reg  <= 1'b0;
      flag_reg      <= 1'b0;
      abort_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ones_reg      <= ones_next;
      count_reg     <= count_next;
      shreg_reg     <= shreg_next;
      pend_reg      <= pend_next;
      pend_vld_reg  <= pend_vld_next;
      dout_reg      <= dout_next;
      dout_vld_reg  <= dout_vld_next;
      dout_eof_reg  <= dout_eof_next;
      flag_reg      <= flag_next;
      abort_reg     <= abort_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign dout      = dout_reg;
  assign dout_vld  = dout_vld_reg;
  assign dout_eof  = dout_eof_reg;
  assign flag      = flag_reg;
  assign abort     = abort_reg;
  assign frame_err = frame_err_reg;

endmodule
